// File: rtl/cip_sieteseg_pkg.sv
// Shared definitions for the multiplexed seven-segment AXI-Lite peripheral:
// register map, CTRL field positions and the hex-to-segment table.
package cip_sieteseg_pkg;

    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_DIGITS   = 2'd1;
    localparam logic [1:0] REG_DP       = 2'd2;
    localparam logic [1:0] REG_PRESCALE = 2'd3;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_BLANK_LSB  = 8;
    localparam int CTRL_BLANK_MSB  = 15;

    // Active-high segment codes, bit0 = a ... bit6 = g; element 0 is the last entry.
    localparam logic [15:0][6:0] HEX_SEGMENTS = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) merged[8*b +: 8] = new_val[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/cip_sieteseg_mux_seg7_hex_decoder.sv
// Combinational hex nibble to active-high seven-segment pattern.
module seg7_hex_decoder
    import cip_sieteseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    assign segments = HEX_SEGMENTS[nibble];

endmodule

// File: rtl/cip_sieteseg_mux.sv
// AXI4-Lite slave driving an N-digit multiplexed seven-segment display:
// register file, digit scanner and registered pin drivers.
module cip_sieteseg_mux
    import cip_sieteseg_pkg::*;
#(
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 4,
    parameter int C_NUM_DIGITS         = 4,
    parameter int C_SCAN_DIV           = 50000,
    parameter bit C_ACTIVE_LOW         = 1'b1
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_areset,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic [7:0]                        sieteseg,
    output logic [C_NUM_DIGITS-1:0]           anodo
);

    localparam int IDX_W = (C_NUM_DIGITS > 1) ? $clog2(C_NUM_DIGITS) : 1;
    localparam logic [7:0]              SEG_OFF = {8{C_ACTIVE_LOW}};
    localparam logic [C_NUM_DIGITS-1:0] AN_OFF  = {C_NUM_DIGITS{C_ACTIVE_LOW}};
    localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(C_NUM_DIGITS - 1);

    logic        awready_reg, wready_reg, bvalid_reg, arready_reg, rvalid_reg;
    logic [31:0] rdata_reg;
    logic        ctrl_en_reg, ctrl_en_next;
    logic [7:0]  blank_reg, blank_next;
    logic [31:0] digits_reg, digits_next;
    logic [7:0]  dp_reg, dp_next;
    logic [31:0] prescale_reg, prescale_next;
    logic [31:0] scan_cnt_reg, scan_cnt_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [7:0]  seg_reg, seg_next;
    logic [C_NUM_DIGITS-1:0] an_reg, an_next;

    logic        write_fire, read_fire, prescale_wr, scan_tc, lit;
    logic [1:0]  wr_sel, rd_sel;
    logic [31:0] rd_data_next, prescale_eff;
    logic [3:0]  cur_nibble;
    logic [6:0]  hex_segs;
    logic [C_NUM_DIGITS-1:0] anode_on;

    logic unused_ok;
    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    assign wr_sel     = s00_axi_awaddr[3:2];
    assign rd_sel     = s00_axi_araddr[3:2];
    assign write_fire = awready_reg & s00_axi_awvalid & wready_reg & s00_axi_wvalid;
    assign read_fire  = arready_reg & s00_axi_arvalid;
    assign prescale_wr = write_fire && (wr_sel == REG_PRESCALE);

    // Register file next state; reads use the next values so a same-edge write is visible.
    always_comb begin
        ctrl_en_next  = ctrl_en_reg;
        blank_next    = blank_reg;
        digits_next   = digits_reg;
        dp_next       = dp_reg;
        prescale_next = prescale_reg;
        if (write_fire) begin
            case (wr_sel)
                REG_CTRL: begin
                    if (s00_axi_wstrb[CTRL_ENABLE_BIT / 8])
                        ctrl_en_next = s00_axi_wdata[CTRL_ENABLE_BIT];
                    if (s00_axi_wstrb[CTRL_BLANK_LSB / 8])
                        blank_next = s00_axi_wdata[CTRL_BLANK_MSB:CTRL_BLANK_LSB];
                end
                REG_DIGITS: digits_next = apply_wstrb(digits_reg, s00_axi_wdata, s00_axi_wstrb);
                REG_DP: begin
                    if (s00_axi_wstrb[0]) dp_next = s00_axi_wdata[7:0];
                end
                default: prescale_next = apply_wstrb(prescale_reg, s00_axi_wdata, s00_axi_wstrb);
            endcase
        end
        case (rd_sel)
            REG_CTRL:   rd_data_next = {16'h0, blank_next, 7'h0, ctrl_en_next};
            REG_DIGITS: rd_data_next = digits_next;
            REG_DP:     rd_data_next = {24'h0, dp_next};
            default:    rd_data_next = prescale_next;
        endcase
    end

    always_comb begin
        prescale_eff  = (prescale_reg == 32'd0) ? 32'd1 : prescale_reg;
        scan_tc       = (scan_cnt_reg >= prescale_eff - 32'd1);
        scan_cnt_next = scan_cnt_reg + 32'd1;
        idx_next      = idx_reg;
        if (prescale_wr) begin
            scan_cnt_next = 32'd0;
        end else if (scan_tc) begin
            scan_cnt_next = 32'd0;
            idx_next      = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < C_NUM_DIGITS; gi++) begin : g_anode
            assign anode_on[gi] = (idx_reg == IDX_W'(gi));
        end
    endgenerate

    assign cur_nibble = digits_reg[{idx_reg, 2'b00} +: 4];

    seg7_hex_decoder u_hex (
        .nibble   (cur_nibble),
        .segments (hex_segs)
    );

    always_comb begin
        lit      = ctrl_en_reg && !blank_reg[idx_reg];
        seg_next = lit ? ({dp_reg[idx_reg], hex_segs} ^ SEG_OFF) : SEG_OFF;
        an_next  = lit ? (anode_on ^ AN_OFF) : AN_OFF;
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            awready_reg  <= 1'b0;
            wready_reg   <= 1'b0;
            bvalid_reg   <= 1'b0;
            arready_reg  <= 1'b0;
            rvalid_reg   <= 1'b0;
            rdata_reg    <= 32'd0;
            ctrl_en_reg  <= 1'b0;
            blank_reg    <= 8'd0;
            digits_reg   <= 32'd0;
            dp_reg       <= 8'd0;
            prescale_reg <= 32'(C_SCAN_DIV);
            scan_cnt_reg <= 32'd0;
            idx_reg      <= '0;
            seg_reg      <= SEG_OFF;
            an_reg       <= AN_OFF;
        end else begin
            awready_reg <= !awready_reg && s00_axi_awvalid && s00_axi_wvalid && !bvalid_reg;
            wready_reg  <= !awready_reg && s00_axi_awvalid && s00_axi_wvalid && !bvalid_reg;
            if (write_fire)          bvalid_reg <= 1'b1;
            else if (s00_axi_bready) bvalid_reg <= 1'b0;
            arready_reg <= !arready_reg && s00_axi_arvalid && !rvalid_reg;
            if (read_fire) begin
                rvalid_reg <= 1'b1;
                rdata_reg  <= rd_data_next;
            end else if (s00_axi_rready) begin
                rvalid_reg <= 1'b0;
            end
            ctrl_en_reg  <= ctrl_en_next;
            blank_reg    <= blank_next;
            digits_reg   <= digits_next;
            dp_reg       <= dp_next;
            prescale_reg <= prescale_next;
            scan_cnt_reg <= scan_cnt_next;
            idx_reg      <= idx_next;
            seg_reg      <= seg_next;
            an_reg       <= an_next;
        end
    end

    assign s00_axi_awready = awready_reg;
    assign s00_axi_wready  = wready_reg;
    assign s00_axi_bvalid  = bvalid_reg;
    assign s00_axi_bresp   = 2'b00;
    assign s00_axi_arready = arready_reg;
    assign s00_axi_rvalid  = rvalid_reg;
    assign s00_axi_rdata   = rdata_reg;
    assign s00_axi_rresp   = 2'b00;
    assign sieteseg        = seg_reg;
    assign anodo           = an_reg;

endmodule

// File: tb/tb_cip_sieteseg_mux.sv
// Self-checking bench: AXI-Lite register traffic plus a cycle-level model of
// the display pins derived from elapsed time since the last prescale change.
module tb_cip_sieteseg_mux;

    localparam int NUM_DIGITS = 4;
    localparam int SCAN_DIV   = 50000;
    localparam logic [6:0] HEX_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        clk = 1'b0;
    logic        areset;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [7:0]  sieteseg;
    logic [NUM_DIGITS-1:0] anodo;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state (describes the cycle currently in progress)
    logic [31:0] m_ctrl, m_digits, m_dp, m_pre;
    int          m_anchor;
    longint      m_elapsed;
    logic [7:0]  exp_seg;
    logic [NUM_DIGITS-1:0] exp_an;
    bit          exp_valid = 1'b0;

    cip_sieteseg_mux #(
        .C_S00_AXI_DATA_WIDTH (32),
        .C_S00_AXI_ADDR_WIDTH (4),
        .C_NUM_DIGITS         (NUM_DIGITS),
        .C_SCAN_DIV           (SCAN_DIV),
        .C_ACTIVE_LOW         (1'b1)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_areset  (areset),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .sieteseg        (sieteseg),
        .anodo           (anodo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic int model_idx();
        longint eff;
        eff = (m_pre == 32'd0) ? 64'd1 : longint'(m_pre);
        return int'((longint'(m_anchor) + m_elapsed / eff) % NUM_DIGITS);
    endfunction

    function automatic logic [31:0] model_reg(input int sel);
        case (sel)
            0:       return m_ctrl;
            1:       return m_digits;
            2:       return m_dp;
            default: return m_pre;
        endcase
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    // Pin checker and model update, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (exp_valid) begin
                check("seg_pins", 32'(sieteseg), 32'(exp_seg));
                check("anode_pins", 32'(anodo), 32'(exp_an));
            end
            if (areset) begin
                m_ctrl = 0; m_digits = 0; m_dp = 0; m_pre = SCAN_DIV;
                m_anchor = 0; m_elapsed = 0;
                exp_seg = 8'hFF; exp_an = '1; exp_valid = 1'b1;
            end else if (exp_valid) begin
                int  i;
                bit  lit;
                i   = model_idx();
                lit = m_ctrl[0] && !m_ctrl[8 + i];
                exp_seg = lit ? ~{m_dp[i], HEX_TAB[(m_digits >> (4 * i)) & 32'hF]} : 8'hFF;
                exp_an  = lit ? ~NUM_DIGITS'(1 << i) : '1;
                if (awready && awvalid && wready && wvalid) begin
                    case (awaddr[3:2])
                        2'd0: m_ctrl   = merge(m_ctrl, wdata, wstrb) & 32'h0000_FF01;
                        2'd1: m_digits = merge(m_digits, wdata, wstrb);
                        2'd2: m_dp     = merge(m_dp, wdata, wstrb) & 32'h0000_00FF;
                        default: m_pre = merge(m_pre, wdata, wstrb);
                    endcase
                end
                if (awready && awvalid && wready && wvalid && awaddr[3:2] == 2'd3) begin
                    m_anchor  = i;
                    m_elapsed = 0;
                end else begin
                    m_elapsed++;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_write_accept();
        int n = 0;
        while (!awready && n < 32) begin
            @(posedge clk); #1; n++;
        end
        check("awready_seen", 32'(awready), 32'd1);
        check("wready_seen", 32'(wready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        check("bvalid_rise", 32'(bvalid), 32'd1);
        check("bresp", 32'(bresp), 32'd0);
    endtask

    task automatic write_start(input int sel, input logic [31:0] data, input logic [3:0] strb);
        awaddr = 4'(sel << 2); wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        wait_write_accept();
    endtask

    task automatic write_finish();
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("bvalid_release", 32'(bvalid), 32'd0);
    endtask

    task automatic axi_write(input int sel, input logic [31:0] data, input logic [3:0] strb);
        write_start(sel, data, strb);
        write_finish();
    endtask

    task automatic axi_read(input int sel, output logic [31:0] data);
        int n = 0;
        araddr = 4'(sel << 2); arvalid = 1'b1;
        while (!arready && n < 32) begin
            @(posedge clk); #1; n++;
        end
        check("arready_seen", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("rvalid_rise", 32'(rvalid), 32'd1);
        check("rresp", 32'(rresp), 32'd0);
        data = rdata;
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check("rvalid_release", 32'(rvalid), 32'd0);
    endtask

    task automatic read_check(input int sel);
        logic [31:0] d;
        axi_read(sel, d);
        $display("read reg%0d -> 0x%08h (model 0x%08h)", sel, d, model_reg(sel));
        check($sformatf("readback_reg%0d", sel), d, model_reg(sel));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        areset = 1'b1;
        awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
        araddr = 0; arprot = 0; arvalid = 0; rready = 0;
        repeat (4) @(posedge clk);
        #1 areset = 1'b0;

        check("reset_awready", 32'(awready), 32'd0);
        check("reset_bvalid", 32'(bvalid), 32'd0);
        check("reset_arready", 32'(arready), 32'd0);
        check("reset_rvalid", 32'(rvalid), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_seg", 32'(sieteseg), 32'hFF);
        check("reset_anodo", 32'(anodo), 32'hF);
        for (int s = 0; s < 4; s++) read_check(s);
        axi_read(3, d);
        check("reset_prescale", d, 32'(SCAN_DIV));

        // Plain scan, four cycles per digit
        axi_write(1, 32'h0000_A3F1, 4'hF);
        axi_write(0, 32'h0000_0001, 4'hF);
        axi_write(3, 32'd4, 4'hF);
        $display("write DIGITS=A3F1 CTRL=1 PRESCALE=4");
        idle(40);

        // Fastest scan with decimal points on digits 0 and 2
        axi_write(3, 32'd0, 4'hF);
        axi_write(2, 32'h0000_0005, 4'hF);
        $display("write PRESCALE=0 DP=05");
        idle(20);

        // Blank digit 2
        axi_write(0, 32'h0000_0401, 4'hF);
        axi_write(3, 32'd3, 4'hF);
        $display("write CTRL=0401 PRESCALE=3");
        idle(30);

        // Byte-lane write with a stalled response and a queued second write
        axi_write(1, 32'h0000_1234, 4'hF);
        write_start(1, 32'h0000_5500, 4'b0010);
        awaddr = 4'h8; wdata = 32'h0000_00A0; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bvalid_hold", 32'(bvalid), 32'd1);
            check("stalled_awready", 32'(awready), 32'd0);
        end
        write_finish();
        wait_write_accept();
        write_finish();
        axi_read(1, d);
        $display("wstrb merge readback 0x%08h", d);
        check("digits_merge", d, 32'h0000_5534);
        read_check(2);

        // Random register traffic against the model
        for (int it = 0; it < 80; it++) begin
            int          sel;
            logic [31:0] data;
            logic [3:0]  strb;
            sel  = $urandom_range(0, 3);
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            if (sel == 3) begin
                data = $urandom_range(0, 6);
                strb = 4'hF;
            end
            if (sel == 0 && $urandom_range(0, 3) != 0) data[0] = 1'b1;
            axi_write(sel, data, strb);
            $display("rand write reg%0d data=0x%08h strb=%b", sel, data, strb);
            if ($urandom_range(0, 1) == 1) read_check($urandom_range(0, 3));
            idle($urandom_range(0, 12));
        end

        // Reset while a write response is outstanding
        axi_write(3, 32'd2, 4'hF);
        write_start(0, 32'h0000_0401, 4'hF);
        areset = 1'b1;
        @(posedge clk); #1;
        areset = 1'b0;
        $display("reset during pending write response");
        check("midreset_bvalid", 32'(bvalid), 32'd0);
        check("midreset_awready", 32'(awready), 32'd0);
        axi_read(0, d);
        check("midreset_ctrl", d, 32'd0);
        axi_read(3, d);
        check("midreset_prescale", d, 32'(SCAN_DIV));
        axi_write(2, 32'h0000_00A5, 4'hF);
        axi_read(2, d);
        check("post_reset_dp", d, 32'h0000_00A5);
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
